imem_fetch_arbiter: RTL and testbench

//  Shares the single-port, 1-cycle-latency instruction memory between the core fetch

---
 rtl/imem_fetch_arbiter.sv | 117 +++++++++++
 tb/tb_imem_fetch_arbiter.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/imem_fetch_arbiter.sv
// Round-robin arbiter sharing a single-port, 1-cycle-latency instruction memory
// between the fetch unit (F) and the debug/loader port (D).
module imem_fetch_arbiter #(
    parameter logic [31:0] BASE_ADDRESS    = 32'h0100_0000,
    parameter int unsigned MEM_WORDS       = 1024,
    parameter logic [31:0] NOP_INSTRUCTION = 32'h1111_1111
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        f_req_valid,
    output logic        f_req_ready,
    input  logic [31:0] f_addr,
    input  logic        f_flush,
    output logic        f_rsp_valid,
    output logic [31:0] f_rsp_data,
    output logic        f_rsp_err,
    input  logic        d_req_valid,
    output logic        d_req_ready,
    input  logic [31:0] d_addr,
    output logic        d_rsp_valid,
    output logic [31:0] d_rsp_data,
    output logic        d_rsp_err,
    output logic        mem_read_enable,
    output logic [31:0] mem_address,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned AW = 33;
    localparam logic [AW-1:0] LO = AW'(BASE_ADDRESS);
    localparam logic [AW-1:0] HI = AW'(BASE_ADDRESS) + (AW'(MEM_WORDS) << 2);

    typedef enum logic { SIDE_F = 1'b0, SIDE_D = 1'b1 } side_e;
    typedef enum logic { IDLE = 1'b0, BUSY = 1'b1 } state_e;

    state_e      state_q, state_d;
    side_e       rr_ptr_q;
    side_e       owner_q;
    logic        err_q;
    logic [31:0] f_data_q, d_data_q;

    logic        gnt_f, gnt_d, gnt_any, gnt_legal;
    logic [31:0] gnt_addr;
    logic [AW-1:0] gnt_addr_x;

    // Grant: a lone requester always wins; under contention rr_ptr decides.
    always_comb begin
        gnt_f      = f_req_valid && (!d_req_valid || rr_ptr_q == SIDE_F);
        gnt_d      = d_req_valid && (!f_req_valid || rr_ptr_q == SIDE_D);
        gnt_any    = gnt_f || gnt_d;
        gnt_addr   = gnt_f ? f_addr : d_addr;
        gnt_addr_x = AW'(gnt_addr);
        gnt_legal  = (gnt_addr[1:0] == 2'b00) && (gnt_addr_x >= LO) && (gnt_addr_x < HI);
    end

    assign f_req_ready     = gnt_f;
    assign d_req_ready     = gnt_d;
    assign mem_read_enable = gnt_any && gnt_legal;
    assign mem_address     = mem_read_enable ? gnt_addr : 32'h0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Slot FSM plus response routing; a flush only squashes the fetch already in flight.
    always_comb begin
        state_d     = state_q;
        f_rsp_valid = 1'b0;
        d_rsp_valid = 1'b0;
        f_rsp_err   = 1'b0;
        d_rsp_err   = 1'b0;
        f_rsp_data  = f_data_q;
        d_rsp_data  = d_data_q;
        case (state_q)
            IDLE: if (gnt_any) state_d = BUSY;
            BUSY: begin
                if (!gnt_any) state_d = IDLE;
                if (owner_q == SIDE_F) begin
                    if (!f_flush) begin
                        f_rsp_valid = 1'b1;
                        f_rsp_err   = err_q;
                        f_rsp_data  = err_q ? NOP_INSTRUCTION : mem_rdata;
                    end
                end else begin
                    d_rsp_valid = 1'b1;
                    d_rsp_err   = err_q;
                    d_rsp_data  = err_q ? NOP_INSTRUCTION : mem_rdata;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= SIDE_F;
            owner_q  <= SIDE_F;
            err_q    <= 1'b0;
            f_data_q <= NOP_INSTRUCTION;
            d_data_q <= NOP_INSTRUCTION;
        end else begin
            if (f_req_valid && d_req_valid) begin
                rr_ptr_q <= (rr_ptr_q == SIDE_F) ? SIDE_D : SIDE_F;
            end
            if (gnt_any) begin
                owner_q <= gnt_f ? SIDE_F : SIDE_D;
                err_q   <= !gnt_legal;
            end
            if (f_rsp_valid) f_data_q <= f_rsp_data;
            if (d_rsp_valid) d_data_q <= d_rsp_data;
        end
    end

endmodule

// File: tb/tb_imem_fetch_arbiter.sv
// Scoreboard bench for imem_fetch_arbiter: directed stimulus pushes expected
// responses, an independent monitor pops and compares them.
module tb_imem_fetch_arbiter;

    localparam logic [31:0] BASE = 32'h0100_0000;
    localparam logic [31:0] NOP  = 32'h1111_1111;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        f_req_valid, f_req_ready, f_flush, f_rsp_valid, f_rsp_err;
    logic [31:0] f_addr, f_rsp_data;
    logic        d_req_valid, d_req_ready, d_rsp_valid, d_rsp_err;
    logic [31:0] d_addr, d_rsp_data;
    logic        mem_read_enable;
    logic [31:0] mem_address, mem_rdata;

    logic [31:0] mem [1024];

    typedef struct {
        bit          side;  // 0 = F, 1 = D
        logic [31:0] data;
        bit          err;
    } exp_t;
    exp_t exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    imem_fetch_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .f_req_valid(f_req_valid), .f_req_ready(f_req_ready), .f_addr(f_addr),
        .f_flush(f_flush), .f_rsp_valid(f_rsp_valid), .f_rsp_data(f_rsp_data),
        .f_rsp_err(f_rsp_err),
        .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_addr(d_addr),
        .d_rsp_valid(d_rsp_valid), .d_rsp_data(d_rsp_data), .d_rsp_err(d_rsp_err),
        .mem_read_enable(mem_read_enable), .mem_address(mem_address),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory model: registered read, data the cycle after issue.
    always @(posedge clk) begin
        if (mem_read_enable) begin
            mem_rdata <= mem[10'((mem_address - BASE) >> 2)];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Expected response for an accepted address, computed from the memory image.
    function automatic exp_t mk_exp(input bit side, input logic [31:0] a);
        exp_t e;
        logic [32:0] ax;
        ax = {1'b0, a};
        e.side = side;
        if (a[1:0] == 2'b00 && ax >= {1'b0, BASE} && ax < {1'b0, BASE} + 33'd4096) begin
            e.err  = 1'b0;
            e.data = mem[10'((a - BASE) >> 2)];
        end else begin
            e.err  = 1'b1;
            e.data = NOP;
        end
        return e;
    endfunction

    // Monitor: every response must match the head of the scoreboard.
    always @(negedge clk) begin
        if (f_rsp_valid || d_rsp_valid) begin
            exp_t e;
            if (f_rsp_valid && d_rsp_valid) begin
                check("both_rsp_valid", 32'(1), 32'(0));
            end else if (exp_q.size() == 0) begin
                check("unexpected_rsp", {31'b0, d_rsp_valid}, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("rsp_side", {31'b0, d_rsp_valid}, {31'b0, e.side});
                check("rsp_data", e.side ? d_rsp_data : f_rsp_data, e.data);
                check("rsp_err", {31'b0, e.side ? d_rsp_err : f_rsp_err}, {31'b0, e.err});
            end
        end
    end

    // One stimulus cycle, starting and ending at posedge+1.
    task automatic cycle(input bit fv, input logic [31:0] fa, input bit dv,
                         input logic [31:0] da, input bit fl,
                         input bit ef, input bit ed, input bit push);
        f_req_valid = fv; f_addr = fa;
        d_req_valid = dv; d_addr = da;
        f_flush = fl;
        #1;
        check("f_req_ready", {31'b0, f_req_ready}, {31'b0, ef});
        check("d_req_ready", {31'b0, d_req_ready}, {31'b0, ed});
        if (push && ef) exp_q.push_back(mk_exp(1'b0, fa));
        if (push && ed) exp_q.push_back(mk_exp(1'b1, da));
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'hA000_0000 + 32'(i);
        mem[2] = 32'hDEAD_BEEF;
        mem_rdata = 32'h0;
        f_req_valid = 0; d_req_valid = 0; f_flush = 0;
        f_addr = 0; d_addr = 0;
        rst_n = 0;
        #12;
        check("rst_f_rsp_valid", {31'b0, f_rsp_valid}, 32'h0);
        check("rst_d_rsp_valid", {31'b0, d_rsp_valid}, 32'h0);
        check("rst_f_rsp_data", f_rsp_data, NOP);
        check("rst_d_rsp_data", d_rsp_data, NOP);
        check("rst_f_rsp_err", {31'b0, f_rsp_err}, 32'h0);
        @(posedge clk); #1;
        rst_n = 1;
        idle(1);

        // 1: lone fetch of word 2
        f_req_valid = 1; f_addr = 32'h0100_0008; #1;
        check("t1_mem_en", {31'b0, mem_read_enable}, 32'h1);
        check("t1_mem_addr", mem_address, 32'h0100_0008);
        #0;
        cycle(1'b1, 32'h0100_0008, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1);
        idle(1);

        // 2: contention alternates F,D,F,D,F,D
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, 32'h0100_0004 + 32'(8 * i), 1'b1, 32'h0100_0100 + 32'(4 * i),
                  1'b0, (i % 2) == 0, (i % 2) == 1, 1'b1);
        end
        idle(1);

        // 3: illegal debug addresses, then the last legal word
        d_req_valid = 1; d_addr = 32'h0100_1000; #1;
        check("t3_mem_en_past_end", {31'b0, mem_read_enable}, 32'h0);
        check("t3_mem_addr_past_end", mem_address, 32'h0);
        cycle(1'b0, 32'h0, 1'b1, 32'h0100_1000, 1'b0, 1'b0, 1'b1, 1'b1);
        d_addr = 32'h0100_0002; #1;
        check("t3_mem_en_misaligned", {31'b0, mem_read_enable}, 32'h0);
        cycle(1'b0, 32'h0, 1'b1, 32'h0100_0002, 1'b0, 1'b0, 1'b1, 1'b1);
        cycle(1'b0, 32'h0, 1'b1, 32'h0100_0FFC, 1'b0, 1'b0, 1'b1, 1'b1);
        cycle(1'b1, 32'h00FF_FFFC, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1);
        idle(1);
        check("t3_d_data_hold", d_rsp_data, 32'hA000_03FF);

        // 4: flush squashes the in-flight fetch but not the one accepted alongside it
        cycle(1'b1, 32'h0100_0010, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 32'h0100_0014, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1);
        // debug response during a flush must survive
        cycle(1'b0, 32'h0, 1'b1, 32'h0100_0018, 1'b0, 1'b0, 1'b1, 1'b1);
        cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(1);

        // 5: reset while a read is in flight
        cycle(1'b1, 32'h0100_0020, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        f_req_valid = 0;
        rst_n = 0; #1;
        check("t5_f_rsp_valid_in_rst", {31'b0, f_rsp_valid}, 32'h0);
        check("t5_d_rsp_valid_in_rst", {31'b0, d_rsp_valid}, 32'h0);
        check("t5_f_rsp_data_in_rst", f_rsp_data, NOP);
        @(posedge clk); #1;
        rst_n = 1;
        idle(2);
        cycle(1'b1, 32'h0100_0024, 1'b1, 32'h0100_0028, 1'b0, 1'b1, 1'b0, 1'b1);
        cycle(1'b1, 32'h0100_0024, 1'b1, 32'h0100_0028, 1'b0, 1'b0, 1'b1, 1'b1);
        idle(3);

        check("pending_responses", 32'(exp_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
